// File: rtl/pfd_pkg.sv
// Shared types and constants for the phase-frequency detector / TDC.
// No logic; no latency; no flow control.
// Compile-time only: state encoding, default width, saturation helper.
package pfd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } pfd_state_e;

  localparam int CNT_W_DEF = 8;

  // Largest positive value of a w-bit two's-complement word.
  function automatic int sat_limit(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with previous-value register and rising-edge strobe.
// Latency: strobe is high in the cycle after the second flop captures the new level.
// No backpressure; runs every cycle regardless of detector enable.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = d_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/pfd_tdc.sv
// Phase-frequency detector with lead-time counter; optional lock detect under PFD_LOCK_DET_EN.
// Latency: up/dn on the 3rd clk edge after an input is first sampled high; err_valid one cycle after the lagging edge.
// No backpressure: err/err_valid is a one-cycle strobe the loop filter must take.
module pfd_tdc
  import pfd_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF
`ifdef PFD_LOCK_DET_EN
  ,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [CNT_W-1:0] err,
  output logic                    err_valid,
  output logic                    lock
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));

  logic ref_e, fb_e;

  edge_sync u_ref_sync (.clk(clk), .reset(reset), .d_in(ref_in), .rise(ref_e));
  edge_sync u_fb_sync  (.clk(clk), .reset(reset), .d_in(fb_in),  .rise(fb_e));

  pfd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [CNT_W-1:0] err_q, err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    up_q, up_d;
  logic                    dn_q, dn_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_e && fb_e) begin
            err_d       = '0;
            err_valid_d = 1'b1;
          end else if (ref_e) begin
            state_d = LEAD_REF;
            cnt_d   = CNT_W'(1);
          end else if (fb_e) begin
            state_d = LEAD_FB;
            cnt_d   = CNT_W'(1);
          end
        end
        LEAD_REF: begin
          if (fb_e) begin
            err_d       = cnt_q;
            err_valid_d = 1'b1;
            if (ref_e) begin
              cnt_d = CNT_W'(1);
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (ref_e) begin
            cnt_d = CNT_W'(1);  // cycle slip: restart from the newer edge
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LEAD_FB: begin
          if (ref_e) begin
            err_d       = -cnt_q;
            err_valid_d = 1'b1;
            if (fb_e) begin
              cnt_d = CNT_W'(1);
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (fb_e) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    up_d = (state_d == LEAD_REF);
    dn_d = (state_d == LEAD_FB);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
    end
  end

  assign up        = up_q;
  assign dn        = dn_q;
  assign err       = err_q;
  assign err_valid = err_valid_q;

`ifdef PFD_LOCK_DET_EN
  localparam int LW = $clog2(LOCK_CNT + 1);

  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] err_abs;
  logic             in_tol;

  // Judged on the registered strobe, so lock moves the cycle after err_valid.
  always_comb begin
    err_abs = err_q[CNT_W-1] ? -err_q : err_q;
    in_tol  = (err_abs <= CNT_W'(LOCK_TOL));
    lcnt_d  = lcnt_q;
    lock_d  = lock_q;
    if (!enable) begin
      lcnt_d = '0;
    end else if (err_valid_q) begin
      if (!in_tol) begin
        lcnt_d = '0;
      end else if (lcnt_q != LW'(LOCK_CNT)) begin
        lcnt_d = lcnt_q + 1'b1;
      end
      lock_d = (lcnt_d == LW'(LOCK_CNT));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lcnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_tdc.sv
// Scoreboard bench for pfd_tdc: generator pushes expected measurements, monitor pops on err_valid.
module tb_pfd_tdc;

  localparam int MAXV = 127;
`ifdef PFD_LOCK_DET_EN
  localparam int TOL  = 2;
  localparam int LCNT = 8;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b1;
  logic              ref_in = 1'b0;
  logic              fb_in = 1'b0;
  logic              up, dn, err_valid, lock;
  logic signed [7:0] err;

  pfd_tdc dut (
    .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .dn(dn), .err(err), .err_valid(err_valid), .lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int upc;
    int dnc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, want, $time);
    end
  endtask

  // One measurement: leader edge at 0 (and again at s if s>0), follower at s+d.
  task automatic lead(input bit ref_leads, input int d, input int s);
    exp_t e;
    int   mag;
    bit   lead_hi, fol_hi;
    mag   = (d > MAXV) ? MAXV : d;
    e.err = ref_leads ? mag : -mag;
    e.upc = ref_leads ? s + d : 0;
    e.dnc = ref_leads ? 0 : s + d;
    exp_q.push_back(e);
    for (int t = 0; t <= s + d; t++) begin
      @(negedge clk);
      lead_hi = (t == 0) || (s > 0 && t == s);
      fol_hi  = (t == s + d);
      ref_in  = ref_leads ? lead_hi : fol_hi;
      fb_in   = ref_leads ? fol_hi : lead_hi;
    end
    @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int  upc = 0, dnc = 0, err_hold = 0;
  bit  lock_exp = 1'b0;
  int  lcnt = 0;
  initial begin
    exp_t e;
    int   mag;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        check("rst_up", int'(up), 0);
        check("rst_dn", int'(dn), 0);
        check("rst_err_valid", int'(err_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_lock", int'(lock), 0);
        upc = 0; dnc = 0; err_hold = 0; lcnt = 0; lock_exp = 1'b0;
      end else begin
        check("lock", int'(lock), int'(lock_exp));
        if (!enable) begin
          check("dis_up", int'(up), 0);
          check("dis_dn", int'(dn), 0);
          check("dis_err_valid", int'(err_valid), 0);
          upc = 0; dnc = 0; lcnt = 0;
        end
        if (err_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_err_valid actual=1 expected=0 err=%0d at %0t", err, $time);
          end else begin
            e = exp_q.pop_front();
            check("err", int'(err), e.err);
            check("up_cycles", upc, e.upc);
            check("dn_cycles", dnc, e.dnc);
            err_hold = e.err;
`ifdef PFD_LOCK_DET_EN
            mag = (e.err < 0) ? -e.err : e.err;
            if (mag <= TOL) lcnt = (lcnt < LCNT) ? lcnt + 1 : LCNT;
            else lcnt = 0;
            lock_exp = (lcnt == LCNT);
`else
            mag = 0;
`endif
          end
          upc = 0;
          dnc = 0;
        end else begin
          check("err_hold", int'(err), err_hold);
        end
        upc += int'(up);
        dnc += int'(dn);
      end
    end
  end

  initial begin
    int d, s, kind;
    // Reset held with inputs toggling.
    repeat (3) begin
      @(negedge clk);
      ref_in = 1'($urandom_range(0, 1));
      fb_in  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    reset  = 1'b1;
    repeat (6) @(negedge clk);

    lead(1'b1, 5, 0);
    lead(1'b0, 3, 0);
    repeat (8) lead(1'b1, 0, 0);
    lead(1'b1, 200, 0);
    lead(1'b1, 4, 10);

    // Reset in the middle of a reference-led measurement.
    @(negedge clk) ref_in = 1'b1;
    @(negedge clk) ref_in = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    lead(1'b1, 7, 0);

    // Disable mid-measurement, with a reference edge arriving while disabled.
    @(negedge clk) ref_in = 1'b1;
    @(negedge clk) ref_in = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk) ref_in = 1'b1;
    @(negedge clk) ref_in = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    lead(1'b0, 6, 0);

    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 3));
      d    = int'($urandom_range(1, 40));
      s    = int'($urandom_range(2, 15));
      case (kind)
        0: lead(1'b1, d, 0);
        1: lead(1'b0, d, 0);
        2: lead(1'($urandom_range(0, 1)), d, s);
        default: lead(1'b1, 0, 0);
      endcase
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending measurements", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
